// File: rtl/gamma_winner_capture_if.sv
// gamma_winner_capture_if: frame hand-off bus from the gamma winner capture
// stage to the STDP/readout consumer. The producer drives the frame and
// result_valid; the consumer drives result_ready.
interface gamma_winner_capture_if #(
    parameter int NUM_INPUTS = 16,
    parameter int TW         = 4,
    parameter int CW         = 5
);
    logic                     result_valid;
    logic                     result_ready;
    logic [NUM_INPUTS-1:0]    result_mask;
    logic [NUM_INPUTS*TW-1:0] result_times;
    logic [CW-1:0]            result_count;

    modport master (
        output result_valid,
        output result_mask,
        output result_times,
        output result_count,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_mask,
        input  result_times,
        input  result_count,
        output result_ready
    );
endinterface

// File: rtl/gamma_winner_capture.sv
// gamma_winner_capture: sits after the kWTA inhibition block. Runs the
// gamma-cycle timebase, resets the kWTA at each gamma boundary, records the
// first-spike offset of every kWTA output line within a gamma cycle and
// publishes the frame over a valid/ready bus at the boundary.
// Optional build macro WINNER_LIMIT_EN: cap captures at K lines per frame
// (lowest index wins on ties) and expose a saturating excess_spikes_o count.
module gamma_winner_capture #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_INPUTS        = 16,
    parameter int K                 = 4,
    localparam int TW = (GAMMA_CYCLE_WIDTH > 2) ? $clog2(GAMMA_CYCLE_WIDTH) : 1,
    localparam int CW = $clog2(NUM_INPUTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [NUM_INPUTS-1:0] spikes_in_i,
    output logic                  kwta_rst_o,
    output logic [TW-1:0]         gamma_time_o,
    output logic                  overflow_o,
`ifdef WINNER_LIMIT_EN
    output logic [CW-1:0]         excess_spikes_o,
`endif
    gamma_winner_capture_if.master res
);

    localparam logic [TW-1:0] LAST_OFFSET = TW'(GAMMA_CYCLE_WIDTH - 1);

    // Reject configurations the timebase cannot represent.
    if (GAMMA_CYCLE_WIDTH < 2 || PULSE_WIDTH < 1 || NUM_INPUTS < 1 || K < 1) begin : g_cfg_check
        $error("gamma_winner_capture: invalid parameter set");
    end

    function automatic logic [CW-1:0] popcount(input logic [NUM_INPUTS-1:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    // Timebase and edge-detection state
    logic [TW-1:0]         gamma_q, gamma_d;
    logic                  post_bnd_q, post_bnd_d;
    logic [NUM_INPUTS-1:0] prev_q, prev_d;

    // Capture state for the frame in progress
    logic [NUM_INPUTS-1:0]          cap_mask_q, cap_mask_d;
    logic [NUM_INPUTS-1:0][TW-1:0]  cap_time_q, cap_time_d;

    // Published frame
    logic                           valid_q, valid_d;
    logic [NUM_INPUTS-1:0]          res_mask_q, res_mask_d;
    logic [NUM_INPUTS-1:0][TW-1:0]  res_times_q, res_times_d;
    logic [CW-1:0]                  res_count_q, res_count_d;
    logic                           ovf_q, ovf_d;

    // Combinational helpers
    logic                           boundary;
    logic                           publish_ok;
    logic [NUM_INPUTS-1:0]          prev_eff;
    logic [NUM_INPUTS-1:0]          cand;
    logic [NUM_INPUTS-1:0]          accept;
    logic [NUM_INPUTS-1:0]          fin_mask;
    logic [NUM_INPUTS-1:0][TW-1:0]  fin_time;

    assign boundary   = en_i && (gamma_q == LAST_OFFSET);
    assign publish_ok = !valid_q || res.result_ready;

    // Rising-edge candidates; history is ignored at offset 0 so a line that
    // is already high when a new frame opens still registers at time 0.
    always_comb begin
        prev_eff = post_bnd_q ? '0 : prev_q;
        cand     = '0;
        if (en_i) begin
            cand = spikes_in_i & ~prev_eff & ~cap_mask_q;
        end
    end

`ifdef WINNER_LIMIT_EN
    localparam int CNT_MAX = (1 << CW) - 1;

    logic [CW-1:0] excess_q, excess_d;
    int            slots_v;
    int            taken_v;
    int            extra_v;
    int            sum_v;

    // Grant remaining winner slots lowest-index first; count the losers.
    always_comb begin
        accept  = '0;
        taken_v = 0;
        extra_v = 0;
        slots_v = K - int'(popcount(cap_mask_q));
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (cand[i]) begin
                if (taken_v < slots_v) begin
                    accept[i] = 1'b1;
                    taken_v   = taken_v + 1;
                end else begin
                    extra_v = extra_v + 1;
                end
            end
        end
        sum_v    = int'(excess_q) + extra_v;
        excess_d = (sum_v > CNT_MAX) ? CW'(CNT_MAX) : CW'(sum_v);
        if (boundary) begin
            excess_d = '0;
        end
    end

    // Excess counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            excess_q <= '0;
        end else begin
            excess_q <= excess_d;
        end
    end

    assign excess_spikes_o = excess_q;
`else
    assign accept = cand;
`endif

    // Frame contents including this cycle's accepted spikes.
    always_comb begin
        fin_mask = cap_mask_q | accept;
        fin_time = cap_time_q;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (accept[i]) begin
                fin_time[i] = gamma_q;
            end
        end
    end

    // Next-state: timebase, capture clear at boundary, publish/drop, handshake.
    always_comb begin
        gamma_d     = gamma_q;
        post_bnd_d  = post_bnd_q;
        prev_d      = prev_q;
        cap_mask_d  = fin_mask;
        cap_time_d  = fin_time;
        valid_d     = valid_q;
        res_mask_d  = res_mask_q;
        res_times_d = res_times_q;
        res_count_d = res_count_q;
        ovf_d       = ovf_q;

        if (en_i) begin
            gamma_d    = boundary ? '0 : gamma_q + 1'b1;
            prev_d     = spikes_in_i;
            post_bnd_d = boundary;
        end

        if (valid_q && res.result_ready) begin
            valid_d = 1'b0;
        end

        if (boundary) begin
            cap_mask_d = '0;
            cap_time_d = '0;
            if (publish_ok) begin
                valid_d     = 1'b1;
                res_mask_d  = fin_mask;
                res_times_d = fin_time;
                res_count_d = popcount(fin_mask);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // State registers; reset discards capture and any pending frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            gamma_q     <= '0;
            post_bnd_q  <= 1'b0;
            prev_q      <= '0;
            cap_mask_q  <= '0;
            cap_time_q  <= '0;
            valid_q     <= 1'b0;
            res_mask_q  <= '0;
            res_times_q <= '0;
            res_count_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            gamma_q     <= gamma_d;
            post_bnd_q  <= post_bnd_d;
            prev_q      <= prev_d;
            cap_mask_q  <= cap_mask_d;
            cap_time_q  <= cap_time_d;
            valid_q     <= valid_d;
            res_mask_q  <= res_mask_d;
            res_times_q <= res_times_d;
            res_count_q <= res_count_d;
            ovf_q       <= ovf_d;
        end
    end

    assign kwta_rst_o       = rst | boundary;
    assign gamma_time_o     = gamma_q;
    assign overflow_o       = ovf_q;
    assign res.result_valid = valid_q;
    assign res.result_mask  = res_mask_q;
    assign res.result_times = res_times_q;
    assign res.result_count = res_count_q;

endmodule

// File: tb/tb_gamma_winner_capture.sv
// Directed bench for gamma_winner_capture (GAMMA_CYCLE_WIDTH=16, NUM_INPUTS=16).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_gamma_winner_capture;
    localparam int N  = 16;
    localparam int TW = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [N-1:0]  spikes;
    logic          kwta_rst;
    logic [TW-1:0] gtime;
    logic          ovf;
`ifdef WINNER_LIMIT_EN
    logic [CW-1:0] excess;
`endif

    int errors = 0;
    int checks = 0;
    int off;
    int hold [N];

    gamma_winner_capture_if #(.NUM_INPUTS(N), .TW(TW), .CW(CW)) res_if ();

    gamma_winner_capture #(
        .GAMMA_CYCLE_WIDTH(16),
        .PULSE_WIDTH      (8),
        .NUM_INPUTS       (N),
        .K                (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en_i           (en),
        .spikes_in_i    (spikes),
        .kwta_rst_o     (kwta_rst),
        .gamma_time_o   (gtime),
        .overflow_o     (ovf),
`ifdef WINNER_LIMIT_EN
        .excess_spikes_o(excess),
`endif
        .res            (res_if.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [15:0] m,
                             input logic [63:0] t, input logic [4:0] c);
        chk({tag, ".valid"}, 64'(res_if.result_valid), 64'd1);
        chk({tag, ".mask"},  64'(res_if.result_mask),  64'(m));
        chk({tag, ".times"}, res_if.result_times,      t);
        chk({tag, ".count"}, 64'(res_if.result_count), 64'(c));
    endtask

    // One clock: track the expected offset, then advance held spike pulses.
    task automatic cyc();
        @(posedge clk);
        if (rst) off = 0;
        else if (en) off = (off == 15) ? 0 : off + 1;
        #1;
        for (int i = 0; i < N; i++) begin
            if (hold[i] > 0) hold[i]--;
            spikes[i] = (hold[i] != 0);
        end
    endtask

    task automatic wait_to(input int o);
        int n;
        n = 0;
        while (off != o && n < 40) begin
            cyc();
            n++;
        end
        if (off != o) begin
            checks++;
            errors++;
            $display("FAIL wait_to: observed=%0d expected=%0d", off, o);
        end
    endtask

    task automatic fire(input int line);
        hold[line]   = 8;
        spikes[line] = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        spikes = '0;
        res_if.result_ready = 1'b0;
        off = 0;
        for (int i = 0; i < N; i++) hold[i] = 0;

        // Reset / idle frame
        repeat (3) cyc();
        chk("rst.kwta",  64'(kwta_rst), 64'd1);
        chk("rst.valid", 64'(res_if.result_valid), 64'd0);
        chk("rst.gamma", 64'(gtime), 64'd0);
        chk("rst.ovf",   64'(ovf), 64'd0);
        chk("rst.mask",  64'(res_if.result_mask), 64'd0);
        chk("rst.count", 64'(res_if.result_count), 64'd0);
        rst = 1'b0;
        en = 1'b1;
        res_if.result_ready = 1'b1;
        #1;
        chk("f1.kwta_off0", 64'(kwta_rst), 64'd0);
        wait_to(15);
        chk("f1.gamma15",   64'(gtime), 64'd15);
        chk("f1.kwta_bnd",  64'(kwta_rst), 64'd1);
        chk("f1.valid_pre", 64'(res_if.result_valid), 64'd0);
        cyc();
        chk("f1.kwta_after", 64'(kwta_rst), 64'd0);
        chk_frame("f1", 16'h0000, 64'h0, 5'd0);

        // Basic capture: line 3 at 2, line 7 at 9
        wait_to(2);  fire(3);
        wait_to(9);  fire(7);
        wait_to(15); cyc();
        chk_frame("f2", 16'h0088, 64'h0000_0000_9000_2000, 5'd2);

        // Line 7 still high at offset 0; counter hold while disabled
        wait_to(8);
        en = 1'b0;
        cyc(); cyc(); cyc();
        chk("hold.gamma", 64'(gtime), 64'd8);
        en = 1'b1;
        wait_to(15); cyc();
        chk_frame("f3", 16'h0080, 64'h0, 5'd1);

        // Tie at offset 5 plus a spike on the boundary cycle
        wait_to(5);  fire(0); fire(1); fire(2);
        wait_to(15); fire(15);
        chk("f4.kwta_bnd", 64'(kwta_rst), 64'd1);
        cyc();
        chk_frame("f4", 16'h8007, 64'hF000_0000_0000_0555, 5'd4);

        // Backpressure: accept f4, then ready low for two boundaries
        cyc();
        chk("f4.accepted", 64'(res_if.result_valid), 64'd0);
        res_if.result_ready = 1'b0;
        wait_to(15); cyc();
        chk_frame("f5", 16'h8000, 64'h0, 5'd1);
        chk("f5.ovf", 64'(ovf), 64'd0);
        wait_to(4);  fire(9);
        wait_to(8);
        chk("f6.stable_mask", 64'(res_if.result_mask), 64'h8000);
        wait_to(15); cyc();
        chk_frame("f6.held", 16'h8000, 64'h0, 5'd1);
        chk("f6.ovf", 64'(ovf), 64'd1);
        res_if.result_ready = 1'b1;
        cyc();
        chk("f6.accepted", 64'(res_if.result_valid), 64'd0);
        wait_to(3);  fire(10);
        wait_to(15); cyc();
        chk_frame("f7", 16'h0400, 64'h0000_0300_0000_0000, 5'd1);
        chk("f7.ovf_sticky", 64'(ovf), 64'd1);

        // Reset mid-frame with a captured line 4
        wait_to(3);  fire(4);
        wait_to(6);
        rst = 1'b1;
        for (int i = 0; i < N; i++) hold[i] = 0;
        spikes = '0;
        cyc();
        chk("mrst.valid", 64'(res_if.result_valid), 64'd0);
        chk("mrst.ovf",   64'(ovf), 64'd0);
        chk("mrst.gamma", 64'(gtime), 64'd0);
        chk("mrst.kwta",  64'(kwta_rst), 64'd1);
        chk("mrst.mask",  64'(res_if.result_mask), 64'd0);
        rst = 1'b0;
        wait_to(7);  fire(6);
        wait_to(15);
        chk("f9.no_publish", 64'(res_if.result_valid), 64'd0);
        cyc();
        chk_frame("f9", 16'h0040, 64'h0000_0000_0700_0000, 5'd1);

        // Six lines rising together at offset 1
        wait_to(1);
        for (int i = 0; i < 6; i++) fire(i);
        cyc();
`ifdef WINNER_LIMIT_EN
        chk("f10.excess", 64'(excess), 64'd2);
`endif
        wait_to(15); cyc();
`ifdef WINNER_LIMIT_EN
        chk_frame("f10", 16'h000F, 64'h0000_0000_0000_1111, 5'd4);
        chk("f10.excess_clr", 64'(excess), 64'd0);
`else
        chk_frame("f10", 16'h003F, 64'h0000_0000_0011_1111, 5'd6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
